// File: rtl/boot_select_pkg.sv
// Shared types, timing defaults and sizing helpers for the multiboot image selector.
package boot_select_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        ARMED,
        LAUNCH,
        BOOT,
        LOCKOUT
    } state_t;

    localparam int CLK_HZ      = 12000000;
    localparam int DEBOUNCE_MS = 10;
    localparam int HOLD_MS     = 500;

    localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEFAULT_HOLD_CYCLES     = (CLK_HZ / 1000) * HOLD_MS;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int  r;
        longint v;
        r = 0;
        v = 1;
        while (v < longint'(value)) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser followed by a consecutive-sample debouncer.
// The debounced level flips only after DEBOUNCE_CYCLES samples in a row disagree with it.
module btn_debounce
    import boot_select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Count disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_b == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= ~level;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/boot_select.sv
// Multiboot image selector: debounces the buttons, requires exactly one eligible
// button held for HOLD_CYCLES and then released, and then requests a warm boot.
// Outputs are registered so BOOT/S1/S0 feed SB_WARMBOOT glitch-free; sel is loaded
// one cycle before boot rises and never changes afterwards until rst.
module boot_select
    import boot_select_pkg::*;
#(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int SELF_IMAGE      = 0,
    parameter int SKIP_SELF       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [1:0]          sel,
    output logic                boot,
    output logic                armed,
    output logic                lockout
);

    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [1:0]    SELF_IDX  = 2'(SELF_IMAGE);

    logic [NUM_BTNS-1:0] db;
    logic [NUM_BTNS-1:0] cand_mask;
    logic [2:0]          ones;
    logic [1:0]          idx;
    logic                one_hot;
    logic                eligible;
    logic                any;

    state_t              state;
    state_t              state_nx;
    logic [1:0]          cand;
    logic [1:0]          cand_nx;
    logic [HW-1:0]       hold_cnt;
    logic [HW-1:0]       hold_nx;
    logic [1:0]          sel_nx;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_in[i]),
            .level(db[i])
        );
    end

    // Classify the debounced vector: popcount, index of the set bit, eligibility.
    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (db[i]) begin
                ones = ones + 3'd1;
                idx  = 2'(i);
            end
        end
        one_hot  = (ones == 3'd1);
        any      = |db;
        eligible = one_hot && !((SKIP_SELF != 0) && (idx == SELF_IDX));
    end

    // One-hot image of the latched candidate, used to spot any other button.
    always_comb begin
        cand_mask = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (2'(i) == cand) begin
                cand_mask[i] = 1'b1;
            end
        end
    end

    // Next-state logic; hold_cnt defaults to zero so it is clear outside HOLD.
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        hold_nx  = '0;
        sel_nx   = sel;
        case (state)
            IDLE: begin
                if (eligible) begin
                    state_nx = HOLD;
                    cand_nx  = idx;
                end else if (any) begin
                    state_nx = LOCKOUT;
                end
            end
            HOLD: begin
                if (db != cand_mask) begin
                    state_nx = any ? LOCKOUT : IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nx = ARMED;
                end else begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            ARMED: begin
                if (!any) begin
                    state_nx = LAUNCH;
                    sel_nx   = cand;
                end else if (|(db & ~cand_mask)) begin
                    state_nx = LOCKOUT;
                end
            end
            LAUNCH:  state_nx = BOOT;
            BOOT:    state_nx = BOOT;
            LOCKOUT: begin
                if (!any) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, candidate, counter and registered LED/boot outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cand     <= '0;
            hold_cnt <= '0;
            sel      <= '0;
            boot     <= 1'b0;
            armed    <= 1'b0;
            lockout  <= 1'b0;
        end else begin
            state    <= state_nx;
            cand     <= cand_nx;
            hold_cnt <= hold_nx;
            sel      <= sel_nx;
            boot     <= (state_nx == BOOT);
            armed    <= (state_nx == ARMED);
            lockout  <= (state_nx == LOCKOUT);
        end
    end

endmodule
